// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the external 16-bit SRAM data-memory back end.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  // Phase counter width; WAIT_CYCLES is limited to 0..15.
  localparam int CNT_W = 4;

  // Halfword address of one half of the 32-bit word holding byte_addr.
  function automatic logic [31:0] half_addr(input logic [31:0] byte_addr,
                                            input logic [31:0] base,
                                            input logic        half);
    return (((byte_addr - base) >> 2) << 1) | {31'd0, half};
  endfunction

endpackage

// File: rtl/sram_ctrl_phase_timer.sv
// Wait-state counter for one halfword phase; restarted at the start of each phase.
module sram_phase_timer
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic en,
  output logic done
);

  localparam logic [CNT_W-1:0] WAIT_VAL = CNT_W'(WAIT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start)   cnt_d = '0;
    else if (en) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done = (cnt_q == WAIT_VAL);

endmodule

// File: rtl/sram_ctrl.sv
// MEM-stage data memory back end: one 32-bit access as two 16-bit async SRAM phases.
// Optional SRAM_POSTED_WRITE_EN: writes retire in IDLE and complete in the background.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_BASE   = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam logic [31:0] BASE = 32'(ADDR_BASE);

  state_e state_q, state_d;
  op_e    op_q, op_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SRAM_AW-1:0] saddr_q, saddr_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic dq_oe_q, dq_oe_d, ce_n_q, ce_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d;

  logic req, posted_busy;
  logic tmr_start, tmr_en, tmr_done;
  logic drv, drv_half;
  op_e  drv_op;
  logic [31:0] drv_addr, drv_wdata;

  assign req = rd_en | wr_en;

`ifdef SRAM_POSTED_WRITE_EN
  // A write in flight has already been retired, so ready only tracks new requests.
  assign posted_busy = (op_q == OP_WR);
`else
  assign posted_busy = 1'b0;
`endif

  sram_phase_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .start (tmr_start),
    .en    (tmr_en),
    .done  (tmr_done)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    saddr_d   = saddr_q;
    dq_out_d  = dq_out_q;
    dq_oe_d   = 1'b0;
    ce_n_d    = 1'b1;
    we_n_d    = 1'b1;
    oe_n_d    = 1'b1;
    tmr_start = 1'b0;
    tmr_en    = 1'b0;
    ready     = 1'b1;
    drv       = 1'b0;
    drv_half  = HALF_LO;
    drv_op    = op_q;
    drv_addr  = addr_q;
    drv_wdata = wdata_q;

    // Strobes are registered from the next state so they line up with LO/HI.
    case (state_q)
      ST_IDLE: begin
`ifdef SRAM_POSTED_WRITE_EN
        ready = ~req | wr_en;
`else
        ready = ~req;
`endif
        if (req) begin
          op_d      = wr_en ? OP_WR : OP_RD;
          addr_d    = address;
          wdata_d   = write_data;
          tmr_start = 1'b1;
          state_d   = ST_LO;
          drv       = 1'b1;
          drv_op    = op_d;
          drv_addr  = address;
          drv_wdata = write_data;
        end
      end
      ST_LO: begin
        ready = posted_busy & ~req;
        drv   = 1'b1;
        if (tmr_done) begin
          if (op_q == OP_RD) rdata_d[15:0] = sram_dq_in;
          tmr_start = 1'b1;
          state_d   = ST_HI;
          drv_half  = HALF_HI;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_HI: begin
        ready = posted_busy & ~req;
        if (tmr_done) begin
          if (op_q == OP_RD) rdata_d[31:16] = sram_dq_in;
          tmr_start = 1'b1;
          state_d   = ST_DONE;
        end else begin
          tmr_en   = 1'b1;
          drv      = 1'b1;
          drv_half = HALF_HI;
        end
      end
      ST_DONE: begin
        ready   = ~posted_busy | ~req;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (drv) begin
      saddr_d = SRAM_AW'(half_addr(drv_addr, BASE, drv_half));
      ce_n_d  = 1'b0;
      if (drv_op == OP_WR) begin
        dq_oe_d  = 1'b1;
        we_n_d   = 1'b0;
        dq_out_d = (drv_half == HALF_HI) ? drv_wdata[31:16] : drv_wdata[15:0];
      end else begin
        oe_n_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_RD;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      saddr_q  <= '0;
      dq_out_q <= '0;
      dq_oe_q  <= 1'b0;
      ce_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      saddr_q  <= saddr_d;
      dq_out_q <= dq_out_d;
      dq_oe_q  <= dq_oe_d;
      ce_n_q   <= ce_n_d;
      we_n_q   <= we_n_d;
      oe_n_q   <= oe_n_d;
    end
  end

  assign read_data   = rdata_q;
  assign sram_addr   = saddr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_n   = oe_n_q;

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Data-memory back end for the MEM stage. It replaces the on-chip 64-word array with an external 16-bit asynchronous SRAM.
- Accepts the MEM stage's 32-bit word read/write request and translates the byte address to an SRAM word address.
- Performs two 16-bit halfword accesses with programmable wait states.
- Holds `ready` low until the access completes; `ready` feeds the pipeline freeze logic.

Parameters:
- ADDR_BASE, 1024, byte address mapped to SRAM word 0
- WAIT_CYCLES, 2, extra cycles each halfword phase is held (0..15)
- SRAM_AW, 18, SRAM address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rd_en  in  1  MEM-stage read request, level, held until ready=1
- wr_en  in  1  MEM-stage write request, level, held until ready=1
- address  in  32  byte address (ALU result)
- write_data  in  32  store data (Value_Rm)
- read_data  out  32  load result, valid in cycle ready=1 after read
- ready  out  1  0 = freeze pipeline
- sram_addr  out  SRAM_AW  SRAM halfword address
- sram_dq_out  out  16  write data to SRAM
- sram_dq_in  in  16  read data from SRAM
- sram_dq_oe  out  1  1 = controller drives data bus
- sram_ce_n  out  1  chip enable, active low
- sram_we_n  out  1  write enable, active low
- sram_oe_n  out  1  output enable, active low

Behaviour:
- Reset (clk, synchronous, active-high): state IDLE, counter 0, read_data 0, sram_addr 0, sram_dq_out 0, sram_dq_oe 0, sram_ce_n/we_n/oe_n 1. Reset mid-access aborts it immediately; no partial write is retried.
- Address: word = (address - ADDR_BASE) >> 2, 32-bit subtract, bits [1:0] ignored.
  - Low half at sram_addr = {word, 0}, high half at {word, 1}, truncated to SRAM_AW.
  - No range check.
- States: IDLE, LO, HI, DONE.
- IDLE: ready = ~(rd_en | wr_en), combinational.
  - On request: latch address, write_data and op.
  - wr_en has priority if both are asserted.
  - Go to LO with counter = 0.
- LO: drive low-half address; ce_n = 0.
  - Write: dq_oe = 1, dq_out = write_data[15:0], we_n = 0.
  - Read: oe_n = 0.
  - Counter increments each cycle. When counter == WAIT_CYCLES, capture sram_dq_in into read_data[15:0] (read only), then go to HI with counter = 0.
- HI: same as LO for the high half, using bits [31:16]; then go to DONE.
- DONE: ready = 1 for exactly one cycle, SRAM idle (all strobes high, dq_oe = 0); next state IDLE.
- read_data holds its value until the next read completes.
- Latency: ready is low for 2*(WAIT_CYCLES+1)+1 cycles: IDLE-detect cycle plus LO and HI. The request is retired on the DONE cycle.
- Request deasserted mid-access: the access still completes; ready pulses in DONE.
- Back-to-back requests: the IDLE after DONE sees the next request, so there is no bubble beyond the IDLE cycle.

Optional Feature:
- Macro SRAM_POSTED_WRITE_EN.
- Defined:
  - A write seen in IDLE is latched and ready stays 1 that cycle, so the pipeline proceeds; the controller runs LO/HI/DONE in the background with ready unaffected.
  - Any request arriving while busy drives ready = 0 until the controller returns to IDLE, then is handled normally.
  - Reads are unchanged.
- Undefined: writes stall exactly like reads.

Decomposition:
- Package sram_ctrl_pkg:
  - state enum (IDLE, LO, HI, DONE)
  - op encoding (OP_RD, OP_WR)
  - halfword select constants
- Sub-module sram_phase_timer: counter with start/clear input and done output (counter == WAIT_CYCLES), WAIT_CYCLES parameter passed through. Instantiated once, restarted per phase.

Test Plan:
- Write 0xDEADBEEF to address 1028, WAIT_CYCLES = 2:
  - sram_addr 2 with dq_out 0xBEEF, then sram_addr 3 with dq_out 0xDEAD, each for 3 cycles with we_n = 0.
  - ready low 7 cycles, then a 1-cycle pulse.
- Read address 1028 with the SRAM model holding words 0xBEEF (addr 2) and 0xDEAD (addr 3): read_data = 0xDEADBEEF in the ready=1 cycle; no we_n activity.
- rd_en and wr_en both asserted at address 1024: write performed (we_n pulses); read_data unchanged.
- rst asserted in HI of a write: next cycle IDLE, all strobes high, ready = 1 with no request; subsequent read at 1032 runs a full access.
- Two back-to-back reads at 1024 and 1036 (WAIT_CYCLES = 0): ready pattern 0,0,0,1,0,0,0,1; values correct.
- SRAM_POSTED_WRITE_EN defined: write at 1024 gives ready = 1 in the request cycle; a read issued the next cycle sees ready low until the write finishes, then reads back the written data.
